// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the 4-digit 7-segment scan sequencer.
package seg_scan_ctrl_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Active-low one-cold anode pattern for a digit index.
    function automatic logic [3:0] anode_select(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

    // True when the digit at idx and every digit to its left are zero.
    function automatic logic upper_zero(input logic [15:0] word, input logic [1:0] idx);
        logic [15:0] rest;
        rest = word >> {idx, 2'b00};
        return (rest == 16'h0000);
    endfunction

endpackage

// File: rtl/seg_phase_timer.sv
// Loadable down-counter that times the BLANK and SHOW phases; done is high at count zero.
module seg_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Saturates at zero so an un-reloaded phase never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display with blanking gaps,
// leading-zero suppression and frame-aligned commit of new display words.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 1,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        lz_en,
    output logic [3:0]  digit,
    output logic [3:0]  anode,
    output logic        load_ack,
    output logic        frame_done
);

    localparam bit               HAS_BLANK  = (BLANK > 0);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [1:0]       LAST_IDX   = 2'(NUM_DIGITS - 1);

    scan_state_t      state, state_nx;
    logic [1:0]       idx, idx_nx;
    logic [15:0]      active, active_nx;
    logic [15:0]      shadow, shadow_nx;
    logic             pending, pending_nx;
    logic [3:0]       digit_nx, anode_nx;
    logic             load_ack_nx, frame_done_nx;
    logic             boundary, entry, commit;
    logic             timer_load, timer_done;
    logic [CNT_W-1:0] timer_val;

    seg_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            active     <= 16'h0000;
            shadow     <= 16'h0000;
            pending    <= 1'b0;
            digit      <= 4'h0;
            anode      <= ANODE_OFF;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            active     <= active_nx;
            shadow     <= shadow_nx;
            pending    <= pending_nx;
            digit      <= digit_nx;
            anode      <= anode_nx;
            load_ack   <= load_ack_nx;
            frame_done <= frame_done_nx;
        end
    end

    // Outputs are computed from the next state so the registered anode/digit line up with it.
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        boundary   = 1'b0;
        entry      = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;

        case (state)
            ST_IDLE: begin
                if (enable) begin
                    entry      = 1'b1;
                    idx_nx     = 2'd0;
                    timer_load = 1'b1;
                    state_nx   = HAS_BLANK ? ST_BLANK : ST_SHOW;
                    timer_val  = HAS_BLANK ? BLANK_LOAD : DWELL_LOAD;
                end
            end
            ST_BLANK: begin
                if (timer_done) begin
                    state_nx   = ST_SHOW;
                    timer_load = 1'b1;
                    timer_val  = DWELL_LOAD;
                end
            end
            ST_SHOW: begin
                if (timer_done) begin
                    idx_nx     = idx + 2'd1;
                    boundary   = (idx == LAST_IDX);
                    timer_load = 1'b1;
                    state_nx   = HAS_BLANK ? ST_BLANK : ST_SHOW;
                    timer_val  = HAS_BLANK ? BLANK_LOAD : DWELL_LOAD;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Dropping enable abandons the partial frame from any state.
        if (!enable) begin
            state_nx   = ST_IDLE;
            idx_nx     = 2'd0;
            boundary   = 1'b0;
            entry      = 1'b0;
            timer_load = (state != ST_IDLE);
            timer_val  = '0;
        end

        commit     = (boundary || entry) && (pending || load);
        active_nx  = active;
        shadow_nx  = load ? data_in : shadow;
        pending_nx = load ? 1'b1 : pending;
        if (commit) begin
            active_nx  = load ? data_in : shadow;
            pending_nx = 1'b0;
        end

        load_ack_nx   = commit;
        frame_done_nx = boundary;

        digit_nx = digit;
        anode_nx = ANODE_OFF;
        if (state_nx == ST_SHOW) begin
            digit_nx = active_nx[{idx_nx, 2'b00} +: 4];
            if (!(lz_en && (idx_nx != 2'd0) && upper_zero(active_nx, idx_nx))) begin
                anode_nx = anode_select(idx_nx);
            end
        end
    end

endmodule
